oklab2ycbcr: RTL and testbench

Pipelined converter from OKLab (L 0.15 unsigned, a/b S0.13) back to YCbCr (Y 8.4 unsigned, Cb/Cr S7.4). It sits after the OKLab-domain processing stages and returns pixels to the YCbCr pipeline. It is the inverse of the YCbCr→OKLab path, with matching precisions and the same hstr/hend/href sync convention. The latency is fixed at 7 cycles, and data is delay-matched to sync.

---
 rtl/oklab_pkg.sv | 74 +++++++
 rtl/ip_oklab2lms.sv | 110 +++++++++++
 rtl/oklab2ycbcr.sv | 136 +++++++++++++
 tb/tb_oklab2ycbcr.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/oklab_pkg.sv
// Shared constants for the OKLab -> YCbCr return path: fixed-point widths,
// the inverse-M2 and LMS->YCbCr coefficient sets (signed Q3.14), sync record
// and the rounding/saturation helpers used by the cube stages.
package oklab_pkg;

   localparam int OKLAB2YCBCR_LAT = 7;

   localparam int LMS_FRAC  = 15;
   localparam int COEF_FRAC = 14;

   localparam int W_COEF  = 18;                   // Q3.14 incl. sign
   localparam int W_LMS   = 17;                   // S1.15
   localparam int W_P2    = W_LMS + W_COEF;       // a/b x inverse-M2 product
   localparam int W_S3    = W_P2 + 2;             // L + two products
   localparam int W_SQP   = 2 * W_LMS;            // full-precision square
   localparam int W_SQ    = 18;                   // S2.15
   localparam int W_CP    = W_SQ + W_LMS;         // full-precision cube
   localparam int W_CUBE  = 19;                   // S3.15
   localparam int W_P6    = W_CUBE + W_COEF;      // cube x LMS->YCbCr product
   localparam int P6_FRAC = LMS_FRAC + COEF_FRAC; // 29 fraction bits
   localparam int W_S7    = W_P6 + 2;             // sum of three products
   localparam int W_S7S   = W_S7 + 8;             // after the x255 scale

   // inverse M2: a/b contributions to l', m', s'
   localparam logic signed [W_COEF-1:0] C_L_A  =  18'sd6494;
   localparam logic signed [W_COEF-1:0] C_L_B  =  18'sd3536;
   localparam logic signed [W_COEF-1:0] C_M_A  = -18'sd1730;
   localparam logic signed [W_COEF-1:0] C_M_B  = -18'sd1046;
   localparam logic signed [W_COEF-1:0] C_S_A  = -18'sd1466;
   localparam logic signed [W_COEF-1:0] C_S_B  = -18'sd21160;

   // combined LMS -> YCbCr (BT.601 full range), 1.0 maps to 255
   localparam logic signed [W_COEF-1:0] C_Y_L  =  18'sd7764;
   localparam logic signed [W_COEF-1:0] C_Y_M  =  18'sd7581;
   localparam logic signed [W_COEF-1:0] C_Y_S  =  18'sd1038;
   localparam logic signed [W_COEF-1:0] C_CB_L = -18'sd4420;
   localparam logic signed [W_COEF-1:0] C_CB_M = -18'sd10782;
   localparam logic signed [W_COEF-1:0] C_CB_S =  18'sd15203;
   localparam logic signed [W_COEF-1:0] C_CR_L =  18'sd42103;
   localparam logic signed [W_COEF-1:0] C_CR_M = -18'sd44062;
   localparam logic signed [W_COEF-1:0] C_CR_S =  18'sd1959;

   // l'/m'/s' clamp to [-1, 2-2^-15]; cube clamp to [-8, 8)
   localparam logic signed [W_S3-1:0] LMS_MIN  = W_S3'(-(2**LMS_FRAC));
   localparam logic signed [W_S3-1:0] LMS_MAX  = W_S3'(2 * (2**LMS_FRAC) - 1);
   localparam logic signed [W_CP-1:0] CUBE_MIN = W_CP'(-8 * (2**LMS_FRAC));
   localparam logic signed [W_CP-1:0] CUBE_MAX = W_CP'(8 * (2**LMS_FRAC) - 1);

   typedef struct packed {
      logic hstr;
      logic hend;
      logic href;
   } sync_t;

   // Round a 29-fraction-bit accumulator to S1.15 and clamp.
   function automatic logic signed [W_LMS-1:0] lms_round_sat(input logic signed [W_S3-1:0] acc);
      logic signed [W_S3-1:0] r;
      r = (acc + W_S3'(2**(COEF_FRAC-1))) >>> COEF_FRAC;
      if (r < LMS_MIN) return W_LMS'(LMS_MIN);
      if (r > LMS_MAX) return W_LMS'(LMS_MAX);
      return W_LMS'(r);
   endfunction

   // Multiply S2.15 square by S1.15 value, truncate to S3.15 and clamp.
   function automatic logic signed [W_CUBE-1:0] cube_sat(input logic signed [W_SQ-1:0] sq,
                                                          input logic signed [W_LMS-1:0] v);
      logic signed [W_CP-1:0] c;
      c = (W_CP'(sq) * W_CP'(v)) >>> LMS_FRAC;
      if (c < CUBE_MIN) return W_CUBE'(CUBE_MIN);
      if (c > CUBE_MAX) return W_CUBE'(CUBE_MAX);
      return W_CUBE'(c);
   endfunction

endpackage

// File: rtl/ip_oklab2lms.sv
// OKLab -> cubed LMS: input register, inverse-M2 products, sum/round/clamp,
// square, cube. Five register stages; sync travels alongside.
module ip_oklab2lms
   import oklab_pkg::*;
#(
   parameter int CIW_L_KL  = 15,
   parameter int CIW_AB_KL = 13
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CIW_L_KL-1:0]       data_l,
   input  logic signed [CIW_AB_KL:0] data_a,
   input  logic signed [CIW_AB_KL:0] data_b,
   input  sync_t                     line_sync,
   output logic signed [W_CUBE-1:0]  cube_l,
   output logic signed [W_CUBE-1:0]  cube_m,
   output logic signed [W_CUBE-1:0]  cube_s,
   output sync_t                     cube_sync
);

   localparam int SYNC_D = OKLAB2YCBCR_LAT - 2;

   logic signed [W_LMS-1:0]  l_ext, a_ext, b_ext;
   logic signed [W_LMS-1:0]  l_s1, a_s1, b_s1;
   logic signed [W_LMS-1:0]  l_s2;
   logic signed [W_P2-1:0]   p_s2 [6];
   logic signed [W_S3-1:0]   acc [3];
   logic signed [W_LMS-1:0]  lms_s3 [3];
   logic signed [W_SQP-1:0]  sq_full [3];
   logic signed [W_SQ-1:0]   sq_s4 [3];
   logic signed [W_LMS-1:0]  lms_s4 [3];
   sync_t                    sync_q [SYNC_D];

   // L is unsigned, a/b signed; both are aligned to 15 fraction bits
   assign l_ext = signed'(W_LMS'(data_l)) <<< (LMS_FRAC - CIW_L_KL);
   assign a_ext = W_LMS'(data_a) <<< (LMS_FRAC - CIW_AB_KL);
   assign b_ext = W_LMS'(data_b) <<< (LMS_FRAC - CIW_AB_KL);

   // stages 1-2: input register, then the six inverse-M2 products
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_s1 <= '0;
         a_s1 <= '0;
         b_s1 <= '0;
         l_s2 <= '0;
         for (int i = 0; i < 6; i++) p_s2[i] <= '0;
      end else begin
         l_s1    <= l_ext;
         a_s1    <= a_ext;
         b_s1    <= b_ext;
         l_s2    <= l_s1;
         p_s2[0] <= W_P2'(a_s1) * W_P2'(C_L_A);
         p_s2[1] <= W_P2'(b_s1) * W_P2'(C_L_B);
         p_s2[2] <= W_P2'(a_s1) * W_P2'(C_M_A);
         p_s2[3] <= W_P2'(b_s1) * W_P2'(C_M_B);
         p_s2[4] <= W_P2'(a_s1) * W_P2'(C_S_A);
         p_s2[5] <= W_P2'(b_s1) * W_P2'(C_S_B);
      end
   end

   // L lifted to the product scale and added to its two a/b terms
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         acc[i] = (W_S3'(l_s2) <<< COEF_FRAC) + W_S3'(p_s2[2*i]) + W_S3'(p_s2[2*i+1]);
      end
   end

   // full-precision squares of the clamped l'/m'/s'
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         sq_full[i] = W_SQP'(lms_s3[i]) * W_SQP'(lms_s3[i]);
      end
   end

   // stages 3-5: round/clamp, square, cube
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            lms_s3[i] <= '0;
            sq_s4[i]  <= '0;
            lms_s4[i] <= '0;
         end
         cube_l <= '0;
         cube_m <= '0;
         cube_s <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            lms_s3[i] <= lms_round_sat(acc[i]);
            sq_s4[i]  <= W_SQ'(sq_full[i] >>> LMS_FRAC);
            lms_s4[i] <= lms_s3[i];
         end
         cube_l <= cube_sat(sq_s4[0], lms_s4[0]);
         cube_m <= cube_sat(sq_s4[1], lms_s4[1]);
         cube_s <= cube_sat(sq_s4[2], lms_s4[2]);
      end
   end

   // sync delay matched to the five data stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_D; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= line_sync;
         for (int i = 1; i < SYNC_D; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign cube_sync = sync_q[SYNC_D-1];

endmodule

// File: rtl/oklab2ycbcr.sv
// OKLab -> YCbCr converter, 7-cycle fixed latency, one pixel per clock.
// Cubed LMS from ip_oklab2lms goes through the LMS->YCbCr matrix, the x255
// scale, half-up rounding to 4 fraction bits, saturation and href gating.
module oklab2ycbcr
   import oklab_pkg::*;
#(
   parameter int CIW_L_KL  = 15,
   parameter int CIW_AB_KL = 13,
   parameter int COIW_Y    = 8,
   parameter int COPW_Y    = 4,
   parameter int COW_Y     = COIW_Y + COPW_Y
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CIW_L_KL-1:0]       i_data_l,
   input  logic signed [CIW_AB_KL:0] i_data_a_sgn,
   input  logic signed [CIW_AB_KL:0] i_data_b_sgn,
   input  logic                      i_hstr,
   input  logic                      i_hend,
   input  logic                      i_href,
   output logic [COW_Y-1:0]          o_data_y,
   output logic signed [COW_Y:0]     o_data_cb_sgn,
   output logic signed [COW_Y:0]     o_data_cr_sgn,
   output logic                      o_hstr,
   output logic                      o_hend,
   output logic                      o_href
);

   localparam int RND_SH = P6_FRAC - COPW_Y;
   localparam logic signed [W_S7S-1:0] Y_MAX = W_S7S'((2**COW_Y) - 1);
   localparam logic signed [W_S7S-1:0] C_MAX = W_S7S'((2**COW_Y) - 1);
   localparam logic signed [W_S7S-1:0] C_MIN = W_S7S'(-(2**COW_Y));

   logic signed [W_CUBE-1:0] cube_l, cube_m, cube_s;
   sync_t                    line_sync, cube_sync, sync_s6;
   logic signed [W_P6-1:0]   p_y [3];
   logic signed [W_P6-1:0]   p_cb [3];
   logic signed [W_P6-1:0]   p_cr [3];
   logic signed [W_S7S-1:0]  y_rnd, cb_rnd, cr_rnd;
   logic [COW_Y-1:0]         y_nxt;
   logic signed [COW_Y:0]    cb_nxt, cr_nxt;

   // sum three products, x255 as (x<<8)-x, round half-up to COPW_Y bits
   function automatic logic signed [W_S7S-1:0] mac_round(input logic signed [W_P6-1:0] p0,
                                                          input logic signed [W_P6-1:0] p1,
                                                          input logic signed [W_P6-1:0] p2);
      logic signed [W_S7-1:0]  s;
      logic signed [W_S7S-1:0] x;
      s = W_S7'(p0) + W_S7'(p1) + W_S7'(p2);
      x = (W_S7S'(s) <<< 8) - W_S7S'(s);
      return (x + W_S7S'(2**(RND_SH-1))) >>> RND_SH;
   endfunction

   function automatic logic [COW_Y-1:0] sat_y(input logic signed [W_S7S-1:0] v);
      if (v[W_S7S-1]) return '0;
      if (v > Y_MAX)  return '1;
      return COW_Y'(v);
   endfunction

   function automatic logic signed [COW_Y:0] sat_c(input logic signed [W_S7S-1:0] v);
      if (v < C_MIN) return (COW_Y+1)'(C_MIN);
      if (v > C_MAX) return (COW_Y+1)'(C_MAX);
      return (COW_Y+1)'(v);
   endfunction

   assign line_sync = {i_hstr, i_hend, i_href};

   ip_oklab2lms #(
      .CIW_L_KL  (CIW_L_KL),
      .CIW_AB_KL (CIW_AB_KL)
   ) u_oklab2lms (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_l    (i_data_l),
      .data_a    (i_data_a_sgn),
      .data_b    (i_data_b_sgn),
      .line_sync (line_sync),
      .cube_l    (cube_l),
      .cube_m    (cube_m),
      .cube_s    (cube_s),
      .cube_sync (cube_sync)
   );

   // stage 6: nine matrix products
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            p_y[i]  <= '0;
            p_cb[i] <= '0;
            p_cr[i] <= '0;
         end
         sync_s6 <= '0;
      end else begin
         p_y[0]  <= W_P6'(cube_l) * W_P6'(C_Y_L);
         p_y[1]  <= W_P6'(cube_m) * W_P6'(C_Y_M);
         p_y[2]  <= W_P6'(cube_s) * W_P6'(C_Y_S);
         p_cb[0] <= W_P6'(cube_l) * W_P6'(C_CB_L);
         p_cb[1] <= W_P6'(cube_m) * W_P6'(C_CB_M);
         p_cb[2] <= W_P6'(cube_s) * W_P6'(C_CB_S);
         p_cr[0] <= W_P6'(cube_l) * W_P6'(C_CR_L);
         p_cr[1] <= W_P6'(cube_m) * W_P6'(C_CR_M);
         p_cr[2] <= W_P6'(cube_s) * W_P6'(C_CR_S);
         sync_s6 <= cube_sync;
      end
   end

   // stage 7 arithmetic: sum, scale, round, saturate
   always_comb begin
      y_rnd  = mac_round(p_y[0], p_y[1], p_y[2]);
      cb_rnd = mac_round(p_cb[0], p_cb[1], p_cb[2]);
      cr_rnd = mac_round(p_cr[0], p_cr[1], p_cr[2]);
      y_nxt  = sat_y(y_rnd);
      cb_nxt = sat_c(cb_rnd);
      cr_nxt = sat_c(cr_rnd);
   end

   // stage 7 register: data forced to 0 outside href, sync passes as-is
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_data_y      <= '0;
         o_data_cb_sgn <= '0;
         o_data_cr_sgn <= '0;
         o_hstr        <= 1'b0;
         o_hend        <= 1'b0;
         o_href        <= 1'b0;
      end else begin
         o_data_y      <= sync_s6.href ? y_nxt  : '0;
         o_data_cb_sgn <= sync_s6.href ? cb_nxt : '0;
         o_data_cr_sgn <= sync_s6.href ? cr_nxt : '0;
         o_hstr        <= sync_s6.hstr;
         o_hend        <= sync_s6.hend;
         o_href        <= sync_s6.href;
      end
   end

endmodule

// File: tb/tb_oklab2ycbcr.sv
// Bench for oklab2ycbcr: table vectors, hand-written sync/reset sequences and
// a random pixel stream, all scored against a real-valued colour model.
module tb_oklab2ycbcr;

   localparam int LAT = 7;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [14:0]        i_data_l = '0;
   logic signed [13:0] i_data_a_sgn = '0;
   logic signed [13:0] i_data_b_sgn = '0;
   logic               i_hstr = 1'b0, i_hend = 1'b0, i_href = 1'b0;
   logic [11:0]        o_data_y;
   logic signed [12:0] o_data_cb_sgn, o_data_cr_sgn;
   logic               o_hstr, o_hend, o_href;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct { logic hstr, hend, href; int y, cb, cr, tol; } exp_t;
   typedef struct { int l, a, b, y, cb, cr, tol; } vec_t;

   exp_t pend[$];
   vec_t tab[6];

   oklab2ycbcr dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_data_l      (i_data_l),
      .i_data_a_sgn  (i_data_a_sgn),
      .i_data_b_sgn  (i_data_b_sgn),
      .i_hstr        (i_hstr),
      .i_hend        (i_hend),
      .i_href        (i_href),
      .o_data_y      (o_data_y),
      .o_data_cb_sgn (o_data_cb_sgn),
      .o_data_cr_sgn (o_data_cr_sgn),
      .o_hstr        (o_hstr),
      .o_hend        (o_hend),
      .o_href        (o_href)
   );

   always #5 clk = ~clk;

   // coefficient as the hardware holds it: nearest multiple of 2^-14
   function automatic real qc(input real c);
      return $floor(c * 16384.0 + 0.5) / 16384.0;
   endfunction

   function automatic real clampr(input real v, input real lo, input real hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   // value in units of 1.0 -> 8.4 code, half-up, clamped
   function automatic int to_code(input real v, input int lo, input int hi);
      real r;
      r = clampr($floor(v * 255.0 * 16.0 + 0.5), real'(lo), real'(hi));
      return $rtoi(r);
   endfunction

   function automatic exp_t model(input logic hs, he, hr, input int l, a, b, input int tol);
      exp_t e;
      real lr, ar, br, lp, mp, sp, lc, mc, sc;
      e.hstr = hs; e.hend = he; e.href = hr;
      e.y = 0; e.cb = 0; e.cr = 0; e.tol = 0;
      if (hr) begin
         lr = l / 32768.0;
         ar = a / 8192.0;
         br = b / 8192.0;
         lp = clampr(lr + qc(0.3963377774) * ar + qc(0.2158037573) * br, -1.0, 65535.0 / 32768.0);
         mp = clampr(lr - qc(0.1055613458) * ar - qc(0.0638541728) * br, -1.0, 65535.0 / 32768.0);
         sp = clampr(lr - qc(0.0894841775) * ar - qc(1.2914855480) * br, -1.0, 65535.0 / 32768.0);
         lc = clampr(lp * lp * lp, -8.0, 262143.0 / 32768.0);
         mc = clampr(mp * mp * mp, -8.0, 262143.0 / 32768.0);
         sc = clampr(sp * sp * sp, -8.0, 262143.0 / 32768.0);
         e.y  = to_code( qc(0.47389) * lc + qc(0.46273) * mc + qc(0.06338) * sc, 0, 4095);
         e.cb = to_code(-qc(0.26980) * lc - qc(0.65810) * mc + qc(0.92791) * sc, -4096, 4095);
         e.cr = to_code( qc(2.56979) * lc - qc(2.68934) * mc + qc(0.11954) * sc, -4096, 4095);
         e.tol = tol;
      end
      return e;
   endfunction

   function automatic exp_t zero_exp();
      exp_t e;
      e.hstr = 1'b0; e.hend = 1'b0; e.href = 1'b0;
      e.y = 0; e.cb = 0; e.cr = 0; e.tol = 0;
      return e;
   endfunction

   task automatic check_int(input string name, input int got, input int want, input int tol);
      checks++;
      if (got - want > tol || want - got > tol) begin
         errors++;
         $display("FAIL %s step=%0d got=%0d want=%0d tol=%0d", name, cyc, got, want, tol);
      end
   endtask

   // one clock: score the output due now, drive the next input, queue its expectation
   task automatic step(input logic hs, he, hr, input int l, a, b, input exp_t e);
      exp_t o;
      @(negedge clk);
      o = pend.pop_front();
      check_int("sync", int'({o_hstr, o_hend, o_href}), int'({o.hstr, o.hend, o.href}), 0);
      check_int("y",  int'(o_data_y),      o.y,  o.tol);
      check_int("cb", int'(o_data_cb_sgn), o.cb, o.tol);
      check_int("cr", int'(o_data_cr_sgn), o.cr, o.tol);
      i_hstr = hs; i_hend = he; i_href = hr;
      i_data_l     = 15'(l);
      i_data_a_sgn = 14'(a);
      i_data_b_sgn = 14'(b);
      pend.push_back(rst_n ? e : zero_exp());
      cyc++;
   endtask

   task automatic pix(input logic hs, he, hr, input int l, a, b);
      step(hs, he, hr, l, a, b, model(hs, he, hr, l, a, b, 4));
   endtask

   task automatic rnd_pix(input logic hs, he, hr);
      pix(hs, he, hr, int'($urandom_range(0, 32767)),
          int'($urandom_range(0, 4096)) - 2048, int'($urandom_range(0, 4096)) - 2048);
   endtask

   task automatic flush_pend();
      pend.delete();
      for (int i = 0; i < LAT; i++) pend.push_back(zero_exp());
   endtask

   // reset held with sync/data toggling, then quiet inputs and release
   task automatic reset_cycles(input int n);
      for (int i = 0; i < n; i++) rnd_pix(1'($urandom), 1'($urandom), 1'($urandom));
      step(1'b0, 1'b0, 1'b0, 0, 0, 0, zero_exp());
      rst_n = 1'b1;
   endtask

   initial begin
      exp_t e;
      int   len, gap;

      tab[0] = '{32767,    0,    0, 4080, 0, 0, 2};
      tab[1] = '{    0,    0,    0,    0, 0, 0, 0};
      tab[2] = '{16384,    0,    0,  510, 0, 0, 2};
      tab[3] = '{ 8192,    0,    0,   64, 0, 0, 2};
      tab[4] = '{32767, 4096,    0, 4095, 0, 4095, 2};
      e = model(1'b0, 1'b0, 1'b1, 32767, 4096, 0, 2);
      tab[4].cb = e.cb;
      e = model(1'b0, 1'b0, 1'b1, 16384, -1500, 1800, 2);
      tab[5] = '{16384, -1500, 1800, e.y, e.cb, e.cr, 2};

      flush_pend();
      reset_cycles(6);

      // quiet after release: href low, data nonzero, everything must stay 0
      for (int i = 0; i < LAT + 2; i++) rnd_pix(1'b0, 1'b0, 1'b0);

      // table vectors as one line
      for (int i = 0; i < 6; i++) begin
         e.hstr = (i == 0); e.hend = (i == 5); e.href = 1'b1;
         e.y = tab[i].y; e.cb = tab[i].cb; e.cr = tab[i].cr; e.tol = tab[i].tol;
         step(e.hstr, e.hend, 1'b1, tab[i].l, tab[i].a, tab[i].b, e);
      end
      for (int i = 0; i < 3; i++) rnd_pix(1'b0, 1'b0, 1'b0);

      // single-pixel line
      rnd_pix(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) rnd_pix(1'b0, 1'b0, 1'b0);

      // back-to-back 4-pixel lines, no idle cycle between them
      for (int ln = 0; ln < 3; ln++)
         for (int p = 0; p < 4; p++) rnd_pix(p == 0, p == 3, 1'b1);

      // random lines and gaps
      for (int ln = 0; ln < 40; ln++) begin
         len = int'($urandom_range(1, 8));
         gap = int'($urandom_range(0, 3));
         for (int p = 0; p < len; p++) rnd_pix(p == 0, p == len - 1, 1'b1);
         for (int g = 0; g < gap; g++) rnd_pix(1'b0, 1'b0, 1'b0);
      end

      // reset in the middle of a line: in-flight pixels are dropped
      for (int p = 0; p < 3; p++) rnd_pix(p == 0, 1'b0, 1'b1);
      rst_n = 1'b0;
      flush_pend();
      reset_cycles(3);
      for (int i = 0; i < 2; i++) rnd_pix(1'b0, 1'b0, 1'b0);
      for (int p = 0; p < 4; p++) rnd_pix(p == 0, p == 3, 1'b1);

      for (int i = 0; i < LAT + 2; i++) rnd_pix(1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
